// File: rtl/regfile_writer_pkg.sv
// Shared constants and types for the integer register file write/read slice.
package regfile_writer_pkg;

    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_e;

endpackage

// File: rtl/regfile_read_port.sv
// One register file read port: index register, array mux with write-first
// forwarding, x0/INIT zeroing and the output data register.
module regfile_read_port
    import regfile_writer_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_i,
    input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
    input  logic              init_i,
    input  logic              fwd_valid_i,
    input  logic [ADDR_W-1:0] fwd_addr_i,
    input  logic [DATA_W-1:0] fwd_data_i,
    output logic [DATA_W-1:0] rs_data_o
);

    logic [ADDR_W-1:0] rs_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Zeroing has priority over forwarding so x0 and the sweep always read 0.
    always_comb begin
        data_d = mem_i[rs_q];
        if (fwd_valid_i && (fwd_addr_i == rs_q)) begin
            data_d = fwd_data_i;
        end
        if (init_i || (rs_q == '0)) begin
            data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q   <= '0;
            data_q <= '0;
        end else begin
            rs_q   <= rs_i;
            data_q <= data_d;
        end
    end

    assign rs_data_o = data_q;

endmodule

// File: rtl/regfile_writer.sv
// Register file storage with a post-reset clearing sweep, a valid/ready write
// port and two pipelined read ports.
module regfile_writer
    import regfile_writer_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              init_done
);

    localparam int unsigned     DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              wr_ready_q, wr_ready_d;
    logic              init_done_q, init_done_d;

    logic              wr_fire_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;

    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_fire_c = wr_valid && wr_ready_q;

    // Next state and array write decode; the sweep owns the write port in INIT.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = wr_addr;
        mem_wdata_c = wr_data;
        case (state_q)
            RF_INIT: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = sweep_q;
                mem_wdata_c = '0;
                sweep_d     = sweep_q + ADDR_W'(1);
                if (sweep_q == LAST_IDX) begin
                    state_d = RF_RUN;
                end
            end
            RF_RUN: begin
                mem_we_c = wr_fire_c && (wr_addr != '0);
            end
            default: begin
                state_d = RF_INIT;
            end
        endcase
        wr_ready_d  = (state_d == RF_RUN);
        init_done_d = (state_d == RF_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RF_INIT;
            sweep_q     <= '0;
            wr_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            wr_ready_q  <= wr_ready_d;
            init_done_q <= init_done_d;
        end
    end

    // Storage has no reset; the sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs_i        (rs1),
        .mem_i       (mem),
        .init_i      (state_q == RF_INIT),
        .fwd_valid_i (wr_fire_c),
        .fwd_addr_i  (wr_addr),
        .fwd_data_i  (wr_data),
        .rs_data_o   (rs1_data)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs_i        (rs2),
        .mem_i       (mem),
        .init_i      (state_q == RF_INIT),
        .fwd_valid_i (wr_fire_c),
        .fwd_addr_i  (wr_addr),
        .fwd_data_i  (wr_data),
        .rs_data_o   (rs2_data)
    );

    assign wr_ready  = wr_ready_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_writer.sv
// Randomized and directed bench for regfile_writer against a behavioural model.
module tb_regfile_writer;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        init_done;

    int n_checks;
    int n_fail;

    // Model: contents as software sees them, edges since reset release and
    // the index each port sampled at the previous edge.
    logic [31:0] mem_m [32];
    int          edges_m;
    logic [4:0]  p1_m;
    logic [4:0]  p2_m;

    regfile_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit ready, input logic [4:0] idx,
                                           input bit fire, input logic [4:0] wa,
                                           input logic [31:0] wd);
        if (!ready || idx == 5'd0) return 32'h0;
        if (fire && wa == idx) return wd;
        return mem_m[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
        edges_m = 0;
        p1_m    = 5'd0;
        p2_m    = 5'd0;
    endtask

    // Drive one cycle of inputs, clock it, then compare every output.
    task automatic step(input logic v, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit          ready;
        bit          fire;
        logic [31:0] e1;
        logic [31:0] e2;
        wr_valid = v;
        wr_addr  = wa;
        wr_data  = wd;
        rs1      = r1;
        rs2      = r2;
        ready = (edges_m >= 32);
        fire  = v && ready;
        e1 = exp_rd(ready, p1_m, fire, wa, wd);
        e2 = exp_rd(ready, p2_m, fire, wa, wd);
        @(posedge clk);
        #1;
        edges_m++;
        if (fire && wa != 5'd0) mem_m[wa] = wd;
        p1_m = r1;
        p2_m = r2;
        check("wr_ready",  32'(wr_ready),  32'(edges_m >= 32));
        check("init_done", 32'(init_done), 32'(edges_m >= 32));
        check("rs1_data",  rs1_data, e1);
        check("rs2_data",  rs2_data, e2);
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(1'b0, 5'd0, 32'h0, r1, r2);
    endtask

    // Asynchronous reset mid-cycle, held three edges, released on a falling edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_wr_ready",  32'(wr_ready),  32'h0);
        check("rst_init_done", 32'(init_done), 32'h0);
        check("rst_rs1_data",  rs1_data, 32'h0);
        check("rst_rs2_data",  rs2_data, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 32'h0;
        rs1      = 5'd0;
        rs2      = 5'd0;
        model_reset();
        @(negedge clk);
        check("reset_wr_ready",  32'(wr_ready),  32'h0);
        check("reset_init_done", 32'(init_done), 32'h0);
        check("reset_rs1_data",  rs1_data, 32'h0);
        check("reset_rs2_data",  rs2_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write held through the sweep, accepted on the first RUN cycle.
        for (int i = 0; i < 32; i++) step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        check("sweep_init_done", 32'(init_done), 32'h1);
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
        idle(5'd0, 5'd0);
        check("first_write_read", rs1_data, 32'hDEAD_BEEF);

        // Unwritten registers read zero.
        idle(5'd7, 5'd31);
        idle(5'd0, 5'd0);
        check("unwritten_rs1", rs1_data, 32'h0);
        check("unwritten_rs2", rs2_data, 32'h0);

        // Write to x0 handshakes but is discarded.
        step(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        check("x0_read", rs1_data, 32'h0);

        // Forwarding: index registered, write accepted before the data edge.
        idle(5'd9, 5'd10);
        step(1'b1, 5'd9, 32'hCAFE_F00D, 5'd0, 5'd0);
        check("fwd_rs1", rs1_data, 32'hCAFE_F00D);
        check("fwd_rs2_other", rs2_data, 32'h0);

        // Back-to-back pipelined reads.
        step(1'b1, 5'd1, 32'h11, 5'd0, 5'd0);
        step(1'b1, 5'd2, 32'h22, 5'd0, 5'd0);
        step(1'b1, 5'd3, 32'h33, 5'd0, 5'd0);
        idle(5'd1, 5'd3);
        idle(5'd2, 5'd2);
        check("b2b_1", rs1_data, 32'h11);
        idle(5'd3, 5'd1);
        check("b2b_2", rs1_data, 32'h22);
        check("b2b_same_idx", rs2_data, 32'h22);
        idle(5'd0, 5'd0);
        check("b2b_3", rs1_data, 32'h33);

        // Reset mid-stream clears the array via a fresh sweep.
        step(1'b1, 5'd4, 32'hA5A5_A5A5, 5'd4, 5'd0);
        idle(5'd0, 5'd0);
        check("pre_reset_read", rs1_data, 32'hA5A5_A5A5);
        pulse_reset();
        for (int i = 0; i < 32; i++) idle(5'd4, 5'd5);
        idle(5'd4, 5'd5);
        idle(5'd0, 5'd0);
        check("post_reset_rs1", rs1_data, 32'h0);
        check("post_reset_rs2", rs2_data, 32'h0);

        // Random traffic with a reset partway through.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) pulse_reset();
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
